// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared display types, segment constants and width helpers
package seg7_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_ZERO = 7'h7E;

  // Counter must reach the larger of the two phase lengths minus one.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/b_to7seg.sv
// rtl/b_to7seg.sv - registered hex nibble to seven-segment encoder ({A..G}, active-high)
module b_to7seg
  import seg7_scan_ctrl_pkg::*;
(
  input  logic       clk_in,
  input  logic [3:0] nibble_in,
  output logic       o_A,
  output logic       o_B,
  output logic       o_C,
  output logic       o_D,
  output logic       o_E,
  output logic       o_F,
  output logic       o_G
);

  logic [6:0] seg;

  // One cycle of latency: segment pattern registered from the nibble.
  always_ff @(posedge clk_in) begin
    case (nibble_in)
      4'h0:    seg <= SEG_ZERO;
      4'h1:    seg <= 7'h30;
      4'h2:    seg <= 7'h6D;
      4'h3:    seg <= 7'h79;
      4'h4:    seg <= 7'h33;
      4'h5:    seg <= 7'h5B;
      4'h6:    seg <= 7'h5F;
      4'h7:    seg <= 7'h70;
      4'h8:    seg <= 7'h7F;
      4'h9:    seg <= 7'h7B;
      4'hA:    seg <= 7'h77;
      4'hB:    seg <= 7'h1F;
      4'hC:    seg <= 7'h4E;
      4'hD:    seg <= 7'h3D;
      4'hE:    seg <= 7'h4F;
      4'hF:    seg <= 7'h47;
      default: seg <= SEG_OFF;
    endcase
  end

  assign {o_A, o_B, o_C, o_D, o_E, o_F, o_G} = seg;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed seven-segment scan controller with blanking and tear-free updates
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load_in,
  input  logic                    lz_blank_in,
  output logic                    o_A,
  output logic                    o_B,
  output logic                    o_C,
  output logic                    o_D,
  output logic                    o_E,
  output logic                    o_F,
  output logic                    o_G,
  output logic [NUM_DIGITS-1:0]   o_DIG,
  output logic                    frame_done_out
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = cnt_width(REFRESH_DIV, BLANK_CYCLES);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_END  = CW'(REFRESH_DIV - 1);

  scan_state_e           state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic                  frame_end;
  logic [VW-1:0]         shadow, pending;
  logic                  pend_valid;
  logic                  acc;
  logic [NUM_DIGITS-1:0] upper_nz;
  logic                  lit_nx;
  logic [NUM_DIGITS-1:0] dig_nx, dig_en;
  logic [3:0]            nibble;
  logic                  seg_on;
  logic                  enc_a, enc_b, enc_c, enc_d, enc_e, enc_f, enc_g;

  // Phase sequencing: BLANK gap then SHOW slot, advancing the digit at slot end.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    idx_nx    = idx;
    frame_end = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_END) begin
          state_nx = ST_SHOW;
          cnt_nx   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_END) begin
          state_nx  = ST_BLANK;
          cnt_nx    = '0;
          frame_end = (idx == LAST_IDX);
          idx_nx    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nx = ST_BLANK;
        cnt_nx   = '0;
      end
    endcase
  end

  // Digit enable for the next cycle; shadow and idx are stable whenever the next state is SHOW.
  always_comb begin
    acc      = 1'b0;
    upper_nz = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc         = acc | (shadow[4*k +: 4] != 4'h0);
      upper_nz[k] = acc;
    end
    lit_nx = (state_nx == ST_SHOW) && ((idx == '0) || !lz_blank_in || upper_nz[idx]);
    dig_nx = '0;
    if (lit_nx) begin
      dig_nx[idx] = 1'b1;
    end
  end

  // Scan position registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Value capture: loads park in pending and only reach shadow at the frame wrap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shadow     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
    end else if (frame_end) begin
      pend_valid <= 1'b0;
      if (load_in) begin
        shadow <= value_in;
      end else if (pend_valid) begin
        shadow <= pending;
      end
    end else if (load_in) begin
      pending    <= value_in;
      pend_valid <= 1'b1;
    end
  end

  // Registered digit enables and frame pulse (pulse lands in the first BLANK cycle of digit 0).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dig_en         <= '0;
      frame_done_out <= 1'b0;
    end else begin
      dig_en         <= dig_nx;
      frame_done_out <= frame_end;
    end
  end

  assign nibble = shadow[{idx, 2'b00} +: 4];

  b_to7seg u_enc (
    .clk_in    (clk_in),
    .nibble_in (nibble),
    .o_A       (enc_a),
    .o_B       (enc_b),
    .o_C       (enc_c),
    .o_D       (enc_d),
    .o_E       (enc_e),
    .o_F       (enc_f),
    .o_G       (enc_g)
  );

  assign seg_on = |dig_en;
  assign o_A    = enc_a & seg_on;
  assign o_B    = enc_b & seg_on;
  assign o_C    = enc_c & seg_on;
  assign o_D    = enc_d & seg_on;
  assign o_E    = enc_e & seg_on;
  assign o_F    = enc_f & seg_on;
  assign o_G    = enc_g & seg_on;
  assign o_DIG  = DIG_ACTIVE_LOW ? ~dig_en : dig_en;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int SLOT  = B + R;
  localparam int FRAME = N * SLOT;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        lz = 1'b0;
  logic        sa, sb, sc, sd, se, sf, sg;
  logic [3:0]  dig;
  logic        fd;

  int          total = 0;
  int          bad = 0;
  int          edges = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .value_in(value), .load_in(load),
    .lz_blank_in(lz), .o_A(sa), .o_B(sb), .o_C(sc), .o_D(sd), .o_E(se),
    .o_F(sf), .o_G(sg), .o_DIG(dig), .frame_done_out(fd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".dig"}, 32'(dig), 32'h0000000F);
    check({tag, ".seg"}, 32'({sa, sb, sc, sd, se, sf, sg}), 32'h0);
    check({tag, ".fd"}, 32'(fd), 32'h0);
  endtask

  // Expected pins after 'edges' clock edges since reset release, from slot arithmetic.
  task automatic check_outputs(input string tag);
    int         pos, d;
    bit         lit;
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;
    pos     = edges % FRAME;
    d       = pos / SLOT;
    lit     = ((pos % SLOT) >= B) && (d == 0 || !lz || ((m_shadow >> (4 * d)) != 16'h0));
    exp_dig = 4'hF;
    exp_seg = 7'h00;
    if (lit) begin
      exp_dig = ~(4'b0001 << d);
      exp_seg = SEG_TAB[m_shadow[4*d +: 4]];
    end
    check({tag, ".dig"}, 32'(dig), 32'(exp_dig));
    check({tag, ".seg"}, 32'({sa, sb, sc, sd, se, sf, sg}), 32'(exp_seg));
    check({tag, ".fd"}, 32'(fd), 32'(edges > 0 && pos == 0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    edges++;
    if (edges % FRAME == 0) begin
      if (load) m_shadow = value;
      else if (m_pv) m_shadow = m_pend;
      m_pv = 1'b0;
    end else if (load) begin
      m_pend = value;
      m_pv   = 1'b1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_load(input string tag, input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step(tag);
    load  = 1'b0;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Advance until the next edge lands on frame position 'target'; bounded to one frame.
  task automatic align(input string tag, input int target);
    for (int i = 0; i < FRAME && ((edges + 1) % FRAME) != target; i++) step(tag);
  endtask

  initial begin
    #3;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    run("idle", FRAME);

    do_load("ld1234", 16'h1234);
    align("w1234", 0);
    run("f1234", 2 * FRAME);

    lz = 1'b1;
    do_load("ld0005", 16'h0005);
    run("f0005", 2 * FRAME);
    do_load("ld0000", 16'h0000);
    run("f0000", 2 * FRAME);
    do_load("ld0a00", 16'h0A00);
    run("f0a00", 2 * FRAME);
    lz = 1'b0;

    align("wd2", 2 * SLOT + B + 2);
    do_load("ldabcd", 16'hABCD);
    run("fabcd", 2 * FRAME);

    do_load("ldstale", 16'h1111);
    align("wwrap", 0);
    do_load("ldwrap", 16'h9876);
    run("fwrap", FRAME);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      if (i % 200 == 0) lz = 1'($urandom_range(0, 1));
      v = 16'($urandom);
      v = v & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      if ($urandom_range(0, 15) == 0) do_load("rnd", v);
      else step("rnd");
    end

    lz = 1'b0;
    do_load("ldpre", 16'h4321);
    align("wpre", 0);
    run("fpre", SLOT + B + 3);
    do_load("ldlost", 16'h5555);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    edges    = 0;
    m_shadow = '0;
    m_pend   = '0;
    m_pv     = 1'b0;
    @(negedge clk);
    check_reset("held");
    rst_n = 1'b1;
    run("post", 2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
